// File: rtl/cu_step_controller.sv
// Single-step execution controller for the control unit.
// Debounces the board step button and mode switch, then in step mode issues one
// i_next_instr_stimulus pulse per button press while the CU is parked at IF.
// Also counts IF-stage entries and latches the global halt.
module cu_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_btn_step,
  input  logic                   i_sw_step_mode,
  input  logic                   i_IF_stage,
  input  logic                   i_ctrl_halt,
  output logic                   o_ctrl_step_execution,
  output logic                   o_next_instr_stimulus,
  output logic                   o_waiting,
  output logic                   o_halted,
  output logic [COUNT_WIDTH-1:0] o_instr_count
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    StRun,
    StWait,
    StFire,
    StExec,
    StLeave,
    StHalted
  } state_e;

  state_e state_q, state_d;

  // Synchronizer stages
  logic btn_s1_q, btn_s2_q;
  logic sw_s1_q, sw_s2_q;

  // Debounce state
  logic [DbW-1:0] btn_cnt_q, btn_cnt_d;
  logic [DbW-1:0] sw_cnt_q, sw_cnt_d;
  logic           btn_db_q, btn_db_d;
  logic           sw_db_q, sw_db_d;
  logic           btn_db_prev_q;
  logic           press_q;

  logic                   if_q;
  logic                   if_rise;
  logic                   step_mode;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic step_exec_q, stim_q, waiting_q, halted_q;

  assign step_mode = sw_db_q;
  assign if_rise   = i_IF_stage & ~if_q;

  // Debounce next-state: count while synced level differs, toggle after the full window
  always_comb begin
    btn_cnt_d = '0;
    btn_db_d  = btn_db_q;
    if (btn_s2_q != btn_db_q) begin
      if (btn_cnt_q == DbLast) begin
        btn_db_d = ~btn_db_q;
      end else begin
        btn_cnt_d = btn_cnt_q + DbW'(1);
      end
    end

    sw_cnt_d = '0;
    sw_db_d  = sw_db_q;
    if (sw_s2_q != sw_db_q) begin
      if (sw_cnt_q == DbLast) begin
        sw_db_d = ~sw_db_q;
      end else begin
        sw_cnt_d = sw_cnt_q + DbW'(1);
      end
    end
  end

  // Instruction counter: saturating, frozen once halted
  always_comb begin
    count_d = count_q;
    if (if_rise && (state_q != StHalted) && (count_q != '1)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // Step FSM next-state; halt wins over everything including a same-cycle press
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (step_mode && i_IF_stage) state_d = StWait;
      end
      StWait: begin
        if (!step_mode)         state_d = StRun;
        else if (press_q)       state_d = StFire;
      end
      StFire: begin
        state_d = StExec;
      end
      StExec: begin
        if (!step_mode)         state_d = StRun;
        else if (!i_IF_stage)   state_d = StLeave;
      end
      StLeave: begin
        if (if_rise)            state_d = step_mode ? StWait : StRun;
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
      end
    endcase
    if (i_ctrl_halt) state_d = StHalted;
  end

  // Input synchronizers, debounce registers and press edge detector
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_s1_q      <= 1'b0;
      btn_s2_q      <= 1'b0;
      sw_s1_q       <= 1'b0;
      sw_s2_q       <= 1'b0;
      btn_cnt_q     <= '0;
      sw_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      sw_db_q       <= 1'b0;
      btn_db_prev_q <= 1'b0;
      press_q       <= 1'b0;
      if_q          <= 1'b0;
    end else begin
      btn_s1_q      <= i_btn_step;
      btn_s2_q      <= btn_s1_q;
      sw_s1_q       <= i_sw_step_mode;
      sw_s2_q       <= sw_s1_q;
      btn_cnt_q     <= btn_cnt_d;
      sw_cnt_q      <= sw_cnt_d;
      btn_db_q      <= btn_db_d;
      sw_db_q       <= sw_db_d;
      btn_db_prev_q <= btn_db_q;
      // Registered rising edge only; releases never produce a press
      press_q       <= btn_db_q & ~btn_db_prev_q;
      if_q          <= i_IF_stage;
    end
  end

  // FSM state, counter and registered outputs decoded from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StRun;
      count_q     <= '0;
      step_exec_q <= 1'b0;
      stim_q      <= 1'b0;
      waiting_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      step_exec_q <= sw_db_q;
      stim_q      <= (state_d == StFire);
      waiting_q   <= (state_d == StWait);
      halted_q    <= (state_d == StHalted);
    end
  end

  assign o_ctrl_step_execution = step_exec_q;
  assign o_next_instr_stimulus = stim_q;
  assign o_waiting             = waiting_q;
  assign o_halted              = halted_q;
  assign o_instr_count         = count_q;

endmodule

// File: tb/tb_cu_step_controller.sv
// Directed bench for cu_step_controller with a short debounce window and a 4-bit counter.
module tb_cu_step_controller;

  localparam int unsigned Db = 4;
  localparam int unsigned Cw = 4;

  logic          clk;
  logic          rst;
  logic          btn;
  logic          sw;
  logic          if_stage;
  logic          halt;
  logic          step_exec;
  logic          stim;
  logic          waiting;
  logic          halted;
  logic [Cw-1:0] count;

  int total = 0;
  int bad   = 0;

  cu_step_controller #(
    .DEBOUNCE_CYCLES(Db),
    .COUNT_WIDTH    (Cw)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_btn_step           (btn),
    .i_sw_step_mode       (sw),
    .i_IF_stage           (if_stage),
    .i_ctrl_halt          (halt),
    .o_ctrl_step_execution(step_exec),
    .o_next_instr_stimulus(stim),
    .o_waiting            (waiting),
    .o_halted             (halted),
    .o_instr_count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       if_v;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[36];

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".step"}, 32'(step_exec), 0);
    chk({name, ".stim"}, 32'(stim), 0);
    chk({name, ".wait"}, 32'(waiting), 0);
    chk({name, ".halt"}, 32'(halted), 0);
    chk({name, ".cnt"}, 32'(count), 0);
  endtask

  // Hold btn high for n cycles and return how many stimulus pulses appeared and when the first came
  task automatic press_for(input int n, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    btn    = 1'b1;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (stim === 1'b1) begin
        pulses++;
        if (first < 0) first = t;
      end
    end
  endtask

  int pulses;
  int first;
  int stray;

  initial begin
    rst      = 1'b1;
    btn      = 1'b0;
    sw       = 1'b0;
    if_stage = 1'b0;
    halt     = 1'b0;
    ticks(2);
    chk_all_zero("reset0");
    rst = 1'b0;

    // IF toggling in run mode: count = number of IF rises, saturating at 15
    for (int i = 0; i < 36; i++) begin
      vecs[i].if_v    = (i % 2 == 0);
      vecs[i].exp_cnt = ((i / 2 + 1) > 15) ? 4'd15 : 4'(i / 2 + 1);
    end
    for (int i = 0; i < 36; i++) begin
      if_stage = vecs[i].if_v;
      tick();
      chk($sformatf("vec%0d.cnt", i), 32'(count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d.stim", i), 32'(stim), 0);
      chk($sformatf("vec%0d.step", i), 32'(step_exec), 0);
    end

    rst      = 1'b1;
    if_stage = 1'b0;
    tick();
    chk_all_zero("reset1");
    rst = 1'b0;

    // Step mode on: switch debounce takes 2 sync + 4 cycles, then one more to the output
    sw = 1'b1;
    ticks(6);
    chk("sw.step_early", 32'(step_exec), 0);
    tick();
    chk("sw.step_on", 32'(step_exec), 1);
    if_stage = 1'b1;
    tick();
    chk("park.wait", 32'(waiting), 1);
    chk("park.cnt", 32'(count), 1);
    ticks(2);

    // Held press: exactly one pulse, 8 cycles after the button rose; waiting drops with it
    pulses = 0;
    first  = -1;
    btn    = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 7) chk("press.wait_before", 32'(waiting), 1);
      if (t == 8) chk("press.wait_after", 32'(waiting), 0);
      if (stim === 1'b1) begin
        pulses++;
        if (first < 0) first = t;
      end
    end
    chk("press.pulses", 32'(pulses), 1);
    chk("press.latency", 32'(first), 8);
    btn = 1'b0;
    ticks(10);

    // Press while executing (IF still high) is dropped
    press_for(10, pulses, first);
    chk("exec_press.pulses", 32'(pulses), 0);
    if_stage = 1'b0;
    tick();
    if_stage = 1'b1;
    tick();
    chk("reenter.wait", 32'(waiting), 1);
    chk("reenter.cnt", 32'(count), 2);
    // Still holding the old press: nothing queued, nothing new
    press_for(10, pulses, first);
    chk("stale_press.pulses", 32'(pulses), 0);
    chk("stale_press.wait", 32'(waiting), 1);
    btn = 1'b0;
    ticks(10);

    // Short glitches never reach the debounce window
    stray = 0;
    for (int g = 0; g < 5; g++) begin
      btn = 1'b1;
      for (int t = 0; t < 2; t++) begin
        tick();
        if (stim === 1'b1) stray++;
      end
      btn = 1'b0;
      for (int t = 0; t < 3; t++) begin
        tick();
        if (stim === 1'b1) stray++;
      end
    end
    ticks(4);
    chk("glitch.pulses", 32'(stray), 0);
    chk("glitch.wait", 32'(waiting), 1);

    // Fresh press after glitches still sees a clean rising edge
    press_for(12, pulses, first);
    chk("fresh.pulses", 32'(pulses), 1);
    chk("fresh.latency", 32'(first), 8);
    btn = 1'b0;
    ticks(10);

    // Back to WAIT, then halt in the same cycle the press reaches the FSM
    if_stage = 1'b0;
    tick();
    if_stage = 1'b1;
    tick();
    chk("halt.pre_wait", 32'(waiting), 1);
    chk("halt.pre_cnt", 32'(count), 3);
    btn = 1'b1;
    ticks(7);
    halt = 1'b1;
    tick();
    chk("halt.stim", 32'(stim), 0);
    chk("halt.halted", 32'(halted), 1);
    chk("halt.wait", 32'(waiting), 0);
    halt  = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      if_stage = ~if_stage;
      tick();
      if (stim === 1'b1) stray++;
    end
    chk("halt.no_pulse", 32'(stray), 0);
    chk("halt.cnt_frozen", 32'(count), 3);
    chk("halt.sticky", 32'(halted), 1);
    chk("halt.step_follow_on", 32'(step_exec), 1);
    sw  = 1'b0;
    btn = 1'b0;
    ticks(10);
    chk("halt.step_follow_off", 32'(step_exec), 0);
    chk("halt.still", 32'(halted), 1);

    // Reset mid-debounce clears everything on the next cycle
    sw       = 1'b1;
    btn      = 1'b1;
    if_stage = 1'b0;
    ticks(4);
    rst = 1'b1;
    tick();
    chk_all_zero("reset_mid");
    rst = 1'b0;
    sw  = 1'b0;
    btn = 1'b0;
    ticks(10);
    chk_all_zero("reset_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
